prog_mem_param: RTL and testbench
=================================

// Module: prog_mem_param
// PURPOSE
//  Parametrised program/instruction memory for the MIPS core, successor to the fixed 32x32 store.
//  After reset it self-clears to NOP with a hardware sweep FSM. It then serves one read or write per cycle.
//  Write supports byte strobes; reads have a fixed 1-cycle latency.
//  A single indexed debug port replaces per-word outputs. Sits between fetch stage and loader/debug logic.
// PARAMETERS
//  DATA_W      32             word width in bits; must be a multiple of 8
//  DEPTH       32             number of words; must be >= 2
//  ADDR_W      32             width of ADDR bus
//  ADDR_SHIFT  0              index = ADDR >> ADDR_SHIFT (0 = word addressing, 2 = byte addressing)
//  NOP_WORD    32'hF800_0000  fill value after reset; returned on idle, error and init
// PORTS
//  CLK         in   1                   rising-edge clock
//  RESET       in   1                   synchronous, active-low reset
//  MEMREAD     in   1                   read request
//  MEMWRITE    in   1                   write request
//  ADDR        in   ADDR_W              access address
//  WRITE_DATA  in   DATA_W              write data
//  WSTRB       in   DATA_W/8            byte enables; bit k covers WRITE_DATA[8k+7:8k]
//  READ_DATA   out  DATA_W              registered read data
//  RD_VALID    out  1                   READ_DATA holds the result of an accepted access
//  ADDR_ERR    out  1                   1-cycle pulse: request addressed index >= DEPTH
//  READY       out  1                   init sweep complete; requests accepted
//  DBG_IDX     in   $clog2(DEPTH)       debug word index
//  DBG_DATA    out  DATA_W              combinational mem[DBG_IDX]
// BEHAVIOUR
//  Reset (RESET==0 at a rising edge)
//   - state <= INIT, sweep counter <= 0.
//   - READ_DATA <= NOP_WORD; RD_VALID, ADDR_ERR, READY <= 0.
//   - Reset mid-sweep or mid-access abandons it; the sweep restarts at index 0.
//  INIT state
//   - Each cycle: mem[cnt] <= NOP_WORD, cnt++.
//   - The write to DEPTH-1 moves state to RUN; READY=1 from the next cycle.
//   - The sweep takes exactly DEPTH cycles after reset deasserts.
//   - MEMREAD/MEMWRITE are ignored: no write, RD_VALID=0, ADDR_ERR=0.
//  RUN state, idx = ADDR >> ADDR_SHIFT; everything below is registered, latency 1 cycle
//   - {MEMREAD,MEMWRITE}=10, idx<DEPTH: READ_DATA <= mem[idx]; RD_VALID <= 1.
//   - MEMWRITE=1, idx<DEPTH (MEMREAD ignored; write wins):
//       bytes with WSTRB=1 take WRITE_DATA, others keep the old byte;
//       READ_DATA <= merged word (write-through); RD_VALID <= 1.
//   - WSTRB=0 with MEMWRITE=1: memory unchanged; READ_DATA <= old word; RD_VALID <= 1.
//   - Any request with idx>=DEPTH: no write; READ_DATA <= NOP_WORD; RD_VALID <= 0; ADDR_ERR <= 1 for one cycle.
//   - No request: READ_DATA <= NOP_WORD; RD_VALID <= 0; ADDR_ERR <= 0.
//   - Upper ADDR bits beyond the index are not wrapped; they trigger ADDR_ERR.
//   - Read after write to the same idx in the next cycle returns the new word (no hazard).
//  DBG_DATA is asynchronous. It reflects writes from the cycle after the write edge. It is valid during INIT (partially swept).
// STRUCTURE
//  Shared package mips_mem_pkg:
//   - MIPS_NOP constant (32'hF800_0000).
//   - state typedef {INIT, RUN}.
//   - Function strobe_merge(old, new, strb).
//  One sub-module: nop_init_sweeper, containing the counter, INIT/RUN FSM, READY, and sweep write enable/index.
//  The top level muxes sweep vs. user write port into a single-write-port array.
//  The array is a plain reg array, no vendor RAM macro.
// TESTING
//  1. Reset low 3 cycles, then high, DEPTH=32 -> READY=0 for 32 cycles then 1; DBG_DATA=F800_0000 for all idx.
//  2. After READY: write idx 5 = 0x2001_000F, WSTRB=F -> READ_DATA=0x2001_000F, RD_VALID=1 next cycle; read idx 5 returns the same.
//  3. Write 0xAABB_CCDD, WSTRB=4'b0101 over 0x1122_3344 -> mem=0x11BB_33DD; DBG_DATA matches.
//  4. Read ADDR=32 (DEPTH=32) -> ADDR_ERR 1-cycle pulse, READ_DATA=NOP, RD_VALID=0; write ADDR=40 -> no array change.
//  5. MEMREAD=MEMWRITE=1 to idx 7 with 0x1234_5678 -> written; READ_DATA=0x1234_5678.
//  6. Reset asserted at sweep cycle 10 with user data in mem -> sweep restarts at 0; READY only after 32 more cycles.
//     Same checks at ADDR_SHIFT=2, DEPTH=64: ADDR=0x10 hits idx 4.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared constants, state type and byte-strobe merge for MIPS memories
package mips_mem_pkg;

    localparam logic [31:0] MIPS_NOP = 32'hF800_0000;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W      = 256;
    localparam int MERGE_STRB_W = MERGE_W / 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_state_t;

    // Bytes with a set strobe take the new data, the rest keep the old word.
    function automatic logic [MERGE_W-1:0] strobe_merge(
        input logic [MERGE_W-1:0]      old_word,
        input logic [MERGE_W-1:0]      new_word,
        input logic [MERGE_STRB_W-1:0] strb
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MERGE_STRB_W; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/nop_init_sweeper.sv
// rtl/nop_init_sweeper.sv - post-reset NOP fill sequencer with INIT/RUN state and READY
module nop_init_sweeper
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             READY,
    output logic             SWEEP_WE,
    output logic [IDX_W-1:0] SWEEP_IDX
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    mem_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    // State and sweep counter; reset always restarts the sweep from index 0.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One word cleared per cycle; the clear of the last word hands over to RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        SWEEP_WE = 1'b0;
        if (state_q == INIT) begin
            // No array write while reset is held low.
            SWEEP_WE = RESET;
            if (cnt_q == LAST_IDX) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end

    assign READY     = (state_q == RUN);
    assign SWEEP_IDX = cnt_q;

endmodule

// File: rtl/prog_mem_param.sv
// rtl/prog_mem_param.sv - parametrised program memory with NOP init sweep, byte strobes and debug port
module prog_mem_param
    import mips_mem_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 32,
    parameter int                ADDR_W     = 32,
    parameter int                ADDR_SHIFT = 0,
    parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(MIPS_NOP),
    localparam int               IDX_W      = $clog2(DEPTH),
    localparam int               STRB_W     = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEMREAD,
    input  logic              MEMWRITE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WRITE_DATA,
    input  logic [STRB_W-1:0] WSTRB,
    output logic [DATA_W-1:0] READ_DATA,
    output logic              RD_VALID,
    output logic              ADDR_ERR,
    output logic              READY,
    input  logic [IDX_W-1:0]  DBG_IDX,
    output logic [DATA_W-1:0] DBG_DATA
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_we;
    logic [IDX_W-1:0]  sweep_idx;
    logic [ADDR_W-1:0] addr_shifted;
    logic              in_range;
    logic              req;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic              user_we;

    nop_init_sweeper #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sweeper (
        .CLK       (CLK),
        .RESET     (RESET),
        .READY     (READY),
        .SWEEP_WE  (sweep_we),
        .SWEEP_IDX (sweep_idx)
    );

    // Upper address bits are not wrapped: anything past the array is an error.
    assign addr_shifted = ADDR >> ADDR_SHIFT;
    assign in_range     = (addr_shifted < ADDR_W'(DEPTH));
    assign idx          = addr_shifted[IDX_W-1:0];
    assign req          = MEMREAD | MEMWRITE;

    assign old_word    = mem[idx];
    assign merged_word = DATA_W'(strobe_merge(MERGE_W'(old_word), MERGE_W'(WRITE_DATA),
                                              MERGE_STRB_W'(WSTRB)));

    // A write with no strobes rewrites the old word, leaving memory unchanged.
    assign user_we = RESET & READY & MEMWRITE & in_range;

    // Single write port shared by the init sweep and user writes.
    always_ff @(posedge CLK) begin
        if (sweep_we) begin
            mem[sweep_idx] <= NOP_WORD;
        end else if (user_we) begin
            mem[idx] <= merged_word;
        end
    end

    // Registered response: write-through on writes, NOP on idle or error.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            READ_DATA <= NOP_WORD;
            RD_VALID  <= 1'b0;
            ADDR_ERR  <= 1'b0;
        end else if (READY && req && in_range) begin
            READ_DATA <= MEMWRITE ? merged_word : old_word;
            RD_VALID  <= 1'b1;
            ADDR_ERR  <= 1'b0;
        end else begin
            READ_DATA <= NOP_WORD;
            RD_VALID  <= 1'b0;
            ADDR_ERR  <= READY & req;
        end
    end

    assign DBG_DATA = mem[DBG_IDX];

endmodule

// File: tb/tb_prog_mem_param.sv
// tb/tb_prog_mem_param.sv - scoreboard bench for prog_mem_param (word and byte addressed instances)
module tb_prog_mem_param;

    localparam logic [31:0] NOP = 32'hF800_0000;

    typedef struct {
        int          due;
        logic        v;
        logic        e;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic        rd_a, wr_a, rv_a, err_a, ready_a;
    logic [31:0] addr_a, wdata_a, rdata_a, dbg_a;
    logic [3:0]  strb_a;
    logic [4:0]  dbg_idx_a;

    logic        rd_b, wr_b, rv_b, err_b, ready_b;
    logic [31:0] addr_b, wdata_b, rdata_b, dbg_b;
    logic [3:0]  strb_b;
    logic [5:0]  dbg_idx_b;

    prog_mem_param dut_a (
        .CLK(clk), .RESET(resetn), .MEMREAD(rd_a), .MEMWRITE(wr_a), .ADDR(addr_a),
        .WRITE_DATA(wdata_a), .WSTRB(strb_a), .READ_DATA(rdata_a), .RD_VALID(rv_a),
        .ADDR_ERR(err_a), .READY(ready_a), .DBG_IDX(dbg_idx_a), .DBG_DATA(dbg_a)
    );

    prog_mem_param #(.DEPTH(64), .ADDR_SHIFT(2)) dut_b (
        .CLK(clk), .RESET(resetn), .MEMREAD(rd_b), .MEMWRITE(wr_b), .ADDR(addr_b),
        .WRITE_DATA(wdata_b), .WSTRB(strb_b), .READ_DATA(rdata_b), .RD_VALID(rv_b),
        .ADDR_ERR(err_b), .READY(ready_b), .DBG_IDX(dbg_idx_b), .DBG_DATA(dbg_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ra, rb;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mdl [2][64];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int depth_of(input int b);
        return (b == 0) ? 32 : 64;
    endfunction

    function automatic int shift_of(input int b);
        return (b == 0) ? 0 : 2;
    endfunction

    function automatic logic [31:0] addr_of(input int b, input int i);
        return 32'(i) << shift_of(b);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitors: pop when an expectation falls due, flag any stray response.
    exp_t ea;
    always @(negedge clk) begin
        if (qa.size() > 0 && qa[0].due == cyc) begin
            ea = qa.pop_front();
            check($sformatf("resp_a@%0d", cyc), 64'({rv_a, err_a, rdata_a}), 64'({ea.v, ea.e, ea.d}));
        end else if (rv_a === 1'b1 || err_a === 1'b1) begin
            check($sformatf("stray_a@%0d", cyc), 64'({rv_a, err_a}), 64'(0));
        end
    end

    exp_t eb;
    always @(negedge clk) begin
        if (qb.size() > 0 && qb[0].due == cyc) begin
            eb = qb.pop_front();
            check($sformatf("resp_b@%0d", cyc), 64'({rv_b, err_b, rdata_b}), 64'({eb.v, eb.e, eb.d}));
        end else if (rv_b === 1'b1 || err_b === 1'b1) begin
            check($sformatf("stray_b@%0d", cyc), 64'({rv_b, err_b}), 64'(0));
        end
    end

    // Apply one request to instance b for one cycle and queue the expected response.
    task automatic drive(input int b, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        exp_t        e;
        logic [31:0] a_sh;
        int          idx;
        @(posedge clk);
        #1;
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        if (b == 0) begin
            rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = data; strb_a = strb;
        end else begin
            rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = data; strb_b = strb;
        end
        a_sh  = addr >> shift_of(b);
        e.due = cyc + 1;
        e.v   = 1'b0;
        e.e   = 1'b0;
        e.d   = NOP;
        if (rd || wr) begin
            if (a_sh >= 32'(depth_of(b))) begin
                e.e = 1'b1;
            end else begin
                idx = int'(a_sh);
                if (wr) begin
                    for (int k = 0; k < 4; k++) begin
                        if (strb[k]) mdl[b][idx][8*k +: 8] = data[8*k +: 8];
                    end
                end
                e.v = 1'b1;
                e.d = mdl[b][idx];
            end
        end
        if (b == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic dbg_check(input int b, input int idx, input string name);
        if (b == 0) dbg_idx_a = 5'(idx);
        else        dbg_idx_b = 6'(idx);
        #1;
        check(name, 64'((b == 0) ? dbg_a : dbg_b), 64'(mdl[b][idx]));
    endtask

    task automatic dbg_all(input int b);
        for (int i = 0; i < depth_of(b); i++) begin
            dbg_check(b, i, $sformatf("dbg_%0d[%0d]", b, i));
        end
    endtask

    // Count edges from reset release until READY; held writes during INIT must be ignored.
    task automatic measure_ready(output int ca, output int cb);
        int n;
        n  = 0;
        ca = -1;
        cb = -1;
        while ((ca < 0 || cb < 0) && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ca < 0 && ready_a === 1'b1) begin ca = n; wr_a = 1'b0; end
            if (cb < 0 && ready_b === 1'b1) begin cb = n; wr_b = 1'b0; end
        end
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    task automatic all_nop();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++) mdl[b][i] = NOP;
    endtask

    task automatic random_ops(input int n);
        int          b, r, idx;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            b = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                addr = $urandom;
            end else begin
                idx  = int'($urandom_range(0, depth_of(b) - 1));
                addr = addr_of(b, idx) | ((b == 1) ? 32'($urandom_range(0, 3)) : 32'd0);
            end
            drive(b, 1'($urandom), 1'($urandom), addr, $urandom, 4'($urandom_range(0, 15)));
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("drain_a", 64'(qa.size()), 64'(0));
        check("drain_b", 64'(qb.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        rd_a = 0; wr_a = 0; addr_a = 0; wdata_a = 0; strb_a = 0; dbg_idx_a = 0;
        rd_b = 0; wr_b = 0; addr_b = 0; wdata_b = 0; strb_b = 0; dbg_idx_b = 0;
        all_nop();

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 64'({rdata_a, rv_a, err_a, ready_a}), 64'({NOP, 3'b000}));
        check("reset_b", 64'({rdata_b, rv_b, err_b, ready_b}), 64'({NOP, 3'b000}));
        resetn = 1'b1;
        measure_ready(ra, rb);
        check("ready_cycles_a", 64'(ra), 64'(32));
        check("ready_cycles_b", 64'(rb), 64'(64));
        dbg_all(0);
        dbg_all(1);

        // Directed sequence on both instances.
        for (int b = 0; b < 2; b++) begin
            drive(b, 1'b0, 1'b1, addr_of(b, 5), 32'h2001_000F, 4'hF);
            drive(b, 1'b1, 1'b0, addr_of(b, 5), 32'h0, 4'h0);
            drive(b, 1'b0, 1'b1, addr_of(b, 9), 32'h1122_3344, 4'hF);
            drive(b, 1'b0, 1'b1, addr_of(b, 9), 32'hAABB_CCDD, 4'b0101);
            drive(b, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            dbg_check(b, 9, $sformatf("merge_dbg_%0d", b));
            check($sformatf("merge_value_%0d", b), 64'((b == 0) ? dbg_a : dbg_b), 64'(32'h11BB_33DD));
            drive(b, 1'b1, 1'b0, addr_of(b, 9), 32'h0, 4'h0);
            drive(b, 1'b1, 1'b0, addr_of(b, depth_of(b)), 32'h0, 4'h0);
            drive(b, 1'b0, 1'b1, addr_of(b, depth_of(b) + 8), 32'hDEAD_BEEF, 4'hF);
            drive(b, 1'b1, 1'b0, 32'h8000_0000 | addr_of(b, 3), 32'h0, 4'h0);
            drive(b, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            dbg_all(b);
            drive(b, 1'b1, 1'b1, addr_of(b, 7), 32'h1234_5678, 4'hF);
            drive(b, 1'b1, 1'b0, addr_of(b, 7), 32'h0, 4'h0);
            drive(b, 1'b0, 1'b1, addr_of(b, 5), 32'hFFFF_FFFF, 4'h0);
            drive(b, 1'b0, 1'b1, addr_of(b, depth_of(b) - 1), 32'hCAFE_F00D, 4'hF);
            drive(b, 1'b1, 1'b0, addr_of(b, depth_of(b) - 1), 32'h0, 4'h0);
            drive(b, 1'b0, 1'b1, addr_of(b, 0), 32'h0BAD_CAFE, 4'b1000);
            drive(b, 1'b1, 1'b0, addr_of(b, 0), 32'h0, 4'h0);
        end
        drive(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b1, 32'h0000_0013, 32'h5566_7788, 4'hF);
        drive(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);

        random_ops(400);

        // Reset mid-sweep with user data present.
        drive(0, 1'b0, 1'b1, addr_of(0, 20), 32'h0101_2020, 4'hF);
        drive(1, 1'b0, 1'b1, addr_of(1, 50), 32'h0505_5050, 4'hF);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            mdl[0][i] = NOP;
            mdl[1][i] = NOP;
        end
        dbg_check(0, 20, "partial_user_a");
        dbg_check(1, 50, "partial_user_b");
        dbg_check(0, 3, "partial_nop_a");
        dbg_check(1, 9, "partial_nop_b");
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        addr_a = 32'd0; wdata_a = 32'hDEAD_BEEF; strb_a = 4'hF; wr_a = 1'b1;
        addr_b = 32'd0; wdata_b = 32'hDEAD_BEEF; strb_b = 4'hF; wr_b = 1'b1;
        measure_ready(ra, rb);
        check("reready_cycles_a", 64'(ra), 64'(32));
        check("reready_cycles_b", 64'(rb), 64'(64));
        all_nop();
        dbg_all(0);
        dbg_all(1);

        random_ops(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
